// File: rtl/planificador_elevador_pkg.sv
// Shared definitions for the elevator scheduler: state encoding, default floor
// count and the request-bank bit-index helpers.
package planificador_elevador_pkg;

  localparam int N_PISOS = 5;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    SUBIENDO = 2'd1,
    BAJANDO  = 2'd2,
    PUERTA   = 2'd3
  } estadoT;

  function automatic int idxSube(input int piso);
    return 2 * piso;
  endfunction

  function automatic int idxBaja(input int piso);
    return 2 * piso + 1;
  endfunction

endpackage

// File: rtl/planificador_elevador_banco_solicitudes.sv
// Pending-request bank: ORs in request pulses, applies the scheduler's clear
// mask (clear wins over set) and forces the two non-existent request bits to 0.
module banco_solicitudes #(
  parameter int N_PISOS = planificador_elevador_pkg::N_PISOS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2*N_PISOS-1:0]   solIn,
  input  logic [2*N_PISOS-1:0]   limpiar,
  output logic [2*N_PISOS-1:0]   pendientes
);
  import planificador_elevador_pkg::*;

  function automatic logic [2*N_PISOS-1:0] mascaraValidos();
    mascaraValidos = '1;
    mascaraValidos[idxBaja(0)] = 1'b0;
    mascaraValidos[idxSube(N_PISOS-1)] = 1'b0;
  endfunction

  localparam logic [2*N_PISOS-1:0] VALIDOS = mascaraValidos();

  always_ff @(posedge clk) begin
    if (reset) begin
      pendientes <= '0;
    end else begin
      pendientes <= (pendientes | solIn) & ~limpiar & VALIDOS;
    end
  end

endmodule

// File: rtl/planificador_elevador.sv
// Collective-control elevator scheduler: FSM, travel/door down-counters and the
// clear mask handed to the request bank.
//
//   state    | meaning
//   REPOSO   | idle, door closed, waiting for a request
//   SUBIENDO | motor up, travel counter running
//   BAJANDO  | motor down, travel counter running
//   PUERTA   | door open for T_PUERTA cycles, serving the current floor
module planificador_elevador #(
  parameter int N_PISOS  = planificador_elevador_pkg::N_PISOS,
  parameter int T_VIAJE  = 16,
  parameter int T_PUERTA = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2*N_PISOS-1:0] sol_in,
  output logic [2*N_PISOS-1:0] pendientes,
  output logic [2:0]           piso_actual,
  output logic                 motor_sube,
  output logic                 motor_baja,
  output logic                 puerta_abierta,
  output logic                 direccion
);
  import planificador_elevador_pkg::*;

  localparam int CW = $clog2((T_VIAJE > T_PUERTA) ? T_VIAJE : T_PUERTA);
  localparam logic [CW-1:0] CARGA_VIAJE  = CW'(T_VIAJE - 1);
  localparam logic [CW-1:0] CARGA_PUERTA = CW'(T_PUERTA - 1);
  localparam logic [2:0]    PISO_TOPE    = 3'(N_PISOS - 1);

  estadoT               estado, estadoSig;
  logic [2:0]           piso, pisoSig, pisoArriba, pisoAbajo;
  logic                 dir, dirSig;
  logic [CW-1:0]        cntViaje, cntViajeSig, cntPuerta, cntPuertaSig;
  logic [2*N_PISOS-1:0] limpiar;

  function automatic logic hayArriba(input logic [2*N_PISOS-1:0] p, input logic [2:0] f);
    hayArriba = 1'b0;
    for (int i = 0; i < N_PISOS; i++)
      if (i > int'(f) && (p[idxSube(i)] || p[idxBaja(i)])) hayArriba = 1'b1;
  endfunction

  function automatic logic hayAbajo(input logic [2*N_PISOS-1:0] p, input logic [2:0] f);
    hayAbajo = 1'b0;
    for (int i = 0; i < N_PISOS; i++)
      if (i < int'(f) && (p[idxSube(i)] || p[idxBaja(i)])) hayAbajo = 1'b1;
  endfunction

  function automatic logic hayAqui(input logic [2*N_PISOS-1:0] p, input logic [2:0] f);
    hayAqui = 1'b0;
    for (int i = 0; i < N_PISOS; i++)
      if (i == int'(f) && (p[idxSube(i)] || p[idxBaja(i)])) hayAqui = 1'b1;
  endfunction

  function automatic logic pideDir(input logic [2*N_PISOS-1:0] p, input logic [2:0] f,
                                   input logic d);
    pideDir = 1'b0;
    for (int i = 0; i < N_PISOS; i++)
      if (i == int'(f)) pideDir = d ? p[idxSube(i)] : p[idxBaja(i)];
  endfunction

  function automatic logic hayMas(input logic [2*N_PISOS-1:0] p, input logic [2:0] f,
                                  input logic d);
    return d ? hayArriba(p, f) : hayAbajo(p, f);
  endfunction

  function automatic logic debeParar(input logic [2*N_PISOS-1:0] p, input logic [2:0] f,
                                     input logic d);
    return pideDir(p, f, d) || (hayAqui(p, f) && !hayMas(p, f, d)) ||
           (f == 3'd0) || (f == PISO_TOPE);
  endfunction

  function automatic logic [2*N_PISOS-1:0] mascaraLimpieza(input logic [2*N_PISOS-1:0] p,
                                                           input logic [2:0] f,
                                                           input logic d);
    mascaraLimpieza = '0;
    for (int i = 0; i < N_PISOS; i++) begin
      if (i == int'(f)) begin
        if (d) mascaraLimpieza[idxSube(i)] = 1'b1;
        else   mascaraLimpieza[idxBaja(i)] = 1'b1;
        if (!hayMas(p, f, d)) begin
          mascaraLimpieza[idxSube(i)] = 1'b1;
          mascaraLimpieza[idxBaja(i)] = 1'b1;
        end
      end
    end
  endfunction

  assign pisoArriba = (piso == PISO_TOPE) ? piso : piso + 3'd1;
  assign pisoAbajo  = (piso == 3'd0)      ? piso : piso - 3'd1;

  always_comb begin
    estadoSig    = estado;
    pisoSig      = piso;
    dirSig       = dir;
    cntViajeSig  = (cntViaje  != '0) ? cntViaje  - CW'(1) : '0;
    cntPuertaSig = (cntPuerta != '0) ? cntPuerta - CW'(1) : '0;
    limpiar      = '0;

    case (estado)
      REPOSO: begin
        if (hayAqui(pendientes, piso)) begin
          estadoSig    = PUERTA;
          cntPuertaSig = CARGA_PUERTA;
        end else if (hayArriba(pendientes, piso)) begin
          estadoSig   = SUBIENDO;
          dirSig      = 1'b1;
          cntViajeSig = CARGA_VIAJE;
        end else if (hayAbajo(pendientes, piso)) begin
          estadoSig   = BAJANDO;
          dirSig      = 1'b0;
          cntViajeSig = CARGA_VIAJE;
        end
      end
      SUBIENDO: begin
        if (cntViaje == '0) begin
          pisoSig     = pisoArriba;
          cntViajeSig = CARGA_VIAJE;
          if (debeParar(pendientes, pisoArriba, 1'b1)) begin
            estadoSig    = PUERTA;
            cntPuertaSig = CARGA_PUERTA;
          end
        end
      end
      BAJANDO: begin
        if (cntViaje == '0) begin
          pisoSig     = pisoAbajo;
          cntViajeSig = CARGA_VIAJE;
          if (debeParar(pendientes, pisoAbajo, 1'b0)) begin
            estadoSig    = PUERTA;
            cntPuertaSig = CARGA_PUERTA;
          end
        end
      end
      PUERTA: begin
        if (cntPuerta == '0) begin
          if (hayMas(pendientes, piso, dir)) begin
            estadoSig   = dir ? SUBIENDO : BAJANDO;
            cntViajeSig = CARGA_VIAJE;
          end else if (hayMas(pendientes, piso, !dir)) begin
            estadoSig   = dir ? BAJANDO : SUBIENDO;
            dirSig      = !dir;
            cntViajeSig = CARGA_VIAJE;
          end else begin
            estadoSig = REPOSO;
          end
        end
      end
      default: estadoSig = REPOSO;
    endcase

    // Clearing stays active for the whole door period so re-pressed calls are absorbed.
    if (estadoSig == PUERTA)
      limpiar = mascaraLimpieza(pendientes, pisoSig, dirSig);
    else if (estado == PUERTA)
      limpiar = mascaraLimpieza(pendientes, piso, dir);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado    <= REPOSO;
      piso      <= 3'd0;
      dir       <= 1'b1;
      cntViaje  <= '0;
      cntPuerta <= '0;
    end else begin
      estado    <= estadoSig;
      piso      <= pisoSig;
      dir       <= dirSig;
      cntViaje  <= cntViajeSig;
      cntPuerta <= cntPuertaSig;
    end
  end

  banco_solicitudes #(.N_PISOS(N_PISOS)) uBanco (
    .clk        (clk),
    .reset      (reset),
    .solIn      (sol_in),
    .limpiar    (limpiar),
    .pendientes (pendientes)
  );

  assign piso_actual    = piso;
  assign direccion      = dir;
  assign motor_sube     = (estado == SUBIENDO);
  assign motor_baja     = (estado == BAJANDO);
  assign puerta_abierta = (estado == PUERTA);

endmodule

// File: tb/tb_planificador_elevador.sv
// Directed bench for planificador_elevador with T_VIAJE=4, T_PUERTA=3, five floors.
module tb_planificador_elevador;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] solIn;
  logic [9:0] pend;
  logic [2:0] piso;
  logic       motorSube, motorBaja, puerta, dir;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  planificador_elevador #(.N_PISOS(5), .T_VIAJE(4), .T_PUERTA(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .sol_in         (solIn),
    .pendientes     (pend),
    .piso_actual    (piso),
    .motor_sube     (motorSube),
    .motor_baja     (motorBaja),
    .puerta_abierta (puerta),
    .direccion      (dir)
  );

  task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  task automatic esperar(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic salidas(input string tag, input logic s, input logic b, input logic p);
    verificar({tag, "_sube"},   32'(motorSube), 32'(s));
    verificar({tag, "_baja"},   32'(motorBaja), 32'(b));
    verificar({tag, "_puerta"}, 32'(puerta),    32'(p));
  endtask

  initial begin
    reset = 1'b1;
    solIn = '0;
    esperar(3);
    reset = 1'b0;
    esperar(10);
    verificar("idle_piso", 32'(piso), 0);
    verificar("idle_pend", 32'(pend), 0);
    verificar("idle_dir",  32'(dir),  1);
    salidas("idle", 0, 0, 0);

    // Up call at floor 3 from floor 0.
    solIn = 10'h040;
    esperar(1);
    solIn = '0;
    verificar("t2_pend", 32'(pend), 32'h040);
    verificar("t2_sube_e0", 32'(motorSube), 0);
    esperar(1);
    verificar("t2_sube_e1", 32'(motorSube), 1);
    for (int f = 1; f <= 3; f++) begin
      esperar(3);
      verificar("t2_piso_antes", 32'(piso), 32'(f - 1));
      esperar(1);
      verificar("t2_piso", 32'(piso), 32'(f));
    end
    salidas("t2_llegada", 0, 0, 1);
    verificar("t2_pend_limpia", 32'(pend), 0);
    esperar(2);
    verificar("t2_puerta_c3", 32'(puerta), 1);
    esperar(1);
    salidas("t2_reposo", 0, 0, 0);
    verificar("t2_dir", 32'(dir), 1);

    // Parked at floor 3, call at floor 1.
    solIn = 10'h004;
    esperar(1);
    solIn = '0;
    verificar("t3_pend", 32'(pend), 32'h004);
    esperar(1);
    salidas("t3_baja", 0, 1, 0);
    verificar("t3_dir", 32'(dir), 0);
    esperar(4);
    verificar("t3_piso2", 32'(piso), 2);
    esperar(4);
    verificar("t3_piso1", 32'(piso), 1);
    salidas("t3_puerta", 0, 0, 1);
    verificar("t3_pend_limpia", 32'(pend), 0);
    esperar(3);
    salidas("t3_reposo", 0, 0, 0);
    verificar("t3_dir_fin", 32'(dir), 0);

    // Reset ignores sol_in.
    reset = 1'b1;
    solIn = 10'h040;
    esperar(1);
    verificar("t4_pend", 32'(pend), 0);
    verificar("t4_piso", 32'(piso), 0);
    verificar("t4_dir",  32'(dir),  1);
    reset = 1'b0;
    solIn = '0;
    esperar(2);
    salidas("t4_post", 0, 0, 0);
    verificar("t4_pend_post", 32'(pend), 0);

    // Bits 4,5,8(invalid),9 together; clear-wins during door at floor 2.
    solIn = 10'h330;
    esperar(1);
    solIn = '0;
    verificar("t5_pend", 32'(pend), 32'h230);
    esperar(1);
    verificar("t5_sube", 32'(motorSube), 1);
    esperar(4);
    verificar("t5_piso1", 32'(piso), 1);
    verificar("t5_sigue", 32'(motorSube), 1);
    esperar(4);
    verificar("t5_piso2", 32'(piso), 2);
    salidas("t5_puerta2", 0, 0, 1);
    verificar("t5_pend_p2", 32'(pend), 32'h220);
    solIn = 10'h010;
    esperar(1);
    solIn = '0;
    verificar("t5_absorbe", 32'(pend), 32'h220);
    verificar("t5_puerta_abierta", 32'(puerta), 1);
    esperar(2);
    salidas("t5_sale", 1, 0, 0);
    verificar("t5_piso_sale", 32'(piso), 2);
    esperar(8);
    verificar("t5_piso4", 32'(piso), 4);
    salidas("t5_tope", 0, 0, 1);
    verificar("t5_pend_tope", 32'(pend), 32'h020);
    esperar(3);
    salidas("t5_revierte", 0, 1, 0);
    verificar("t5_dir", 32'(dir), 0);
    esperar(8);
    verificar("t5_piso2_baja", 32'(piso), 2);
    verificar("t5_puerta_baja", 32'(puerta), 1);
    verificar("t5_pend_fin", 32'(pend), 0);
    esperar(3);
    salidas("t5_reposo", 0, 0, 0);

    // Reset mid-travel between floors 1 and 2.
    reset = 1'b1;
    esperar(1);
    reset = 1'b0;
    solIn = 10'h040;
    esperar(1);
    solIn = '0;
    esperar(5);
    verificar("t6_piso1", 32'(piso), 1);
    esperar(2);
    verificar("t6_viajando", 32'(motorSube), 1);
    reset = 1'b1;
    esperar(1);
    verificar("t6_piso", 32'(piso), 0);
    verificar("t6_pend", 32'(pend), 0);
    verificar("t6_dir",  32'(dir),  1);
    salidas("t6_reset", 0, 0, 0);
    reset = 1'b0;
    esperar(3);
    salidas("t6_post", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/planificador_elevador.md
PLANIFICADOR_ELEVADOR -- requirements
Module: planificador_elevador

Interface
REQ-001 Parameter N_PISOS: default 5; number of floors, indexed 0..N_PISOS-1.
REQ-002 Parameter T_VIAJE: default 16; clock cycles to travel one floor, at least 2.
REQ-003 Parameter T_PUERTA: default 8; clock cycles the door stays open, at least 2.
REQ-004 clk  in  1  single system clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sol_in  in  2*N_PISOS  request pulses; bit 2i = up request at floor i, bit 2i+1 = down request at floor i.
REQ-007 pendientes  out  2*N_PISOS  registered pending-request bank, same bit map as sol_in.
REQ-008 piso_actual  out  3  current floor index.
REQ-009 motor_sube  out  1  car moving up.
REQ-010 motor_baja  out  1  car moving down.
REQ-011 puerta_abierta  out  1  door open.
REQ-012 direccion  out  1  service direction; 1 = up, 0 = down.

Function
REQ-013 A sol_in bit set to 1 shall set the matching pendientes bit on the next edge; sol_in bits are ORed in, never toggled.
REQ-014 Bit 1 (down at floor 0) and bit 2*N_PISOS-2 (up at top floor) are invalid and shall always read 0.
REQ-015 The FSM states are REPOSO, SUBIENDO, BAJANDO and PUERTA; only the current state drives the outputs.
REQ-016 Outputs by state:
- motor_sube is 1 only in SUBIENDO.
- motor_baja is 1 only in BAJANDO.
- puerta_abierta is 1 only in PUERTA.
- The outputs shall never be 1 at the same time.
REQ-017 REPOSO evaluates in this priority order:
- any request at piso_actual -> PUERTA;
- else any request above -> SUBIENDO with direccion=1;
- else any request below -> BAJANDO with direccion=0;
- else stay in REPOSO.
REQ-018 On entering SUBIENDO or BAJANDO, the travel counter shall load T_VIAJE-1 and decrement each cycle.
REQ-019 When the travel counter reaches 0, piso_actual shall step by 1 in the travel direction on that edge, which is T_VIAJE cycles after entry.
REQ-020 At arrival, the FSM shall enter PUERTA if the floor has a request in direccion, or has any request and none lies further in direccion, or is floor 0 or the top floor; otherwise it reloads the counter and keeps moving.
REQ-021 piso_actual shall never leave 0..N_PISOS-1.
REQ-022 On entering PUERTA:
- the request bit for direccion at that floor is cleared;
- if no request lies further in direccion, both bits of that floor are cleared.
REQ-023 PUERTA shall last exactly T_PUERTA cycles.
REQ-024 When PUERTA ends, the FSM shall:
- continue in direccion if requests lie beyond;
- else reverse if requests lie the other way (updating direccion);
- else go to REPOSO.
REQ-025 In PUERTA, a sol_in bit for the current floor that matches a bit being cleared is absorbed; clear wins over set.
REQ-026 Simultaneous sol_in pulses on several bits shall all register in the same cycle.

Reset
REQ-027 While reset is high, on each clock edge:
- the state goes to REPOSO;
- piso_actual, pendientes and all motor/door outputs go to 0;
- direccion goes to 1;
- both counters go to 0.
REQ-028 Reset shall take effect even mid-travel or mid-door, and sol_in shall be ignored during reset.

Structure
REQ-029 A shared package shall hold the FSM state encoding, N_PISOS, and the bit-index helpers (up index 2i, down index 2i+1).
REQ-030 The request bank (set/clear/invalid-bit masking) shall be a sub-module named banco_solicitudes; the FSM and counters stay in planificador_elevador.

Verification (T_VIAJE=4, T_PUERTA=3)
REQ-031 Reset, then idle 10 cycles -> piso_actual=0, pendientes=0, all motor/door outputs 0, direccion=1.
REQ-032 From floor 0, pulse bit 6 (up at floor 3):
- motor_sube rises one cycle later;
- piso_actual steps 1,2,3 at 4-cycle spacing;
- at floor 3, puerta_abierta is high for 3 cycles, bit 6 is cleared, then the FSM returns to REPOSO.
REQ-033 Car moving up from floor 0 with bits 4 and 5 pending (up and down at floor 2) plus bit 8 (invalid):
- stop at floor 2 clears only bit 4;
- bit 8 always reads 0.
REQ-034 Door open at floor 2 with direccion=1, and bit 4 pulsed again -> bit 4 stays 0 (clear wins).
REQ-035 Car parked at floor 3 with a request at floor 1 -> BAJANDO, direccion=0, piso_actual reaches 1 after 8 cycles and the door opens.
REQ-036 Reset asserted mid-travel between floors 1 and 2 -> next edge gives REPOSO, piso_actual=0, motor_sube=0 and pendientes=0.
